// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the clock/reset controller.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_state_e;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_NDM = 1;

    // Ratios of 0 or 1 cannot produce a two-phase clock, so they collapse to 2.
    function automatic logic [31:0] clamp_div(input logic [31:0] ratio);
        logic [31:0] result;
        if (ratio < 32'd2) begin
            result = 32'd2;
        end else begin
            result = ratio;
        end
        return result;
    endfunction

endpackage

// File: rtl/clk_rst_ctrl_sync_n.sv
// Parametrised flop synchroniser with asynchronous active-low clear.
module sync_n #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift chain; stage 0 captures the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/clk_rst_ctrl.sv
// Programmable clock divider with sequenced reset release and ndmreset merge.
// Optional reset-cause register enabled by defining CLK_RST_CAUSE_EN.
module clk_rst_ctrl
    import clk_rst_pkg::*;
#(
    parameter int DIV_W       = 4,
    parameter int DIV_DEFAULT = 2,
    parameter int N_RST       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int RST_HOLD    = 16,
    parameter int STEP_GAP    = 4
) (
    input  logic             sysclk,
    input  logic             sysrst_n,
    input  logic             ndmreset,
    input  logic [DIV_W-1:0] div_set,
    input  logic             div_load,
`ifdef CLK_RST_CAUSE_EN
    input  logic             cause_clr,
    output logic [1:0]       rst_cause,
`endif
    output logic             clkout,
    output logic             clk_en,
    output logic [N_RST-1:0] rst_n_out,
    output logic             busy,
    output logic [DIV_W-1:0] div_cur
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int GAP_W  = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam int IDX_W  = (N_RST > 1) ? $clog2(N_RST) : 1;
    localparam logic [N_RST-1:0] RST_ONE = N_RST'(1);

    logic rst_int_n_s;
    logic ndm_s;

    sync_n #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .clk   (sysclk),
        .rst_n (sysrst_n),
        .d     (1'b1),
        .q     (rst_int_n_s)
    );

    sync_n #(.STAGES(SYNC_STAGES)) u_ndm_sync (
        .clk   (sysclk),
        .rst_n (sysrst_n),
        .d     (ndmreset),
        .q     (ndm_s)
    );

    // ---------------- divider ----------------
    logic [DIV_W-1:0] cnt_r, div_cur_r, div_pend_r;
    logic             pend_r, clk_en_r, clkout_r;
    logic [DIV_W-1:0] cnt_next_s, div_next_s, load_val_s;
    logic [DIV_W:0]   half_s;
    logic             wrap_s;

    // Divider next-state: wrap detection, pending ratio applied only at the wrap
    always_comb begin
        wrap_s     = (cnt_r == (div_cur_r - DIV_W'(1)));
        load_val_s = DIV_W'(clamp_div(32'(div_set)));
        half_s     = ({1'b0, div_cur_r} + (DIV_W+1)'(1)) >> 1'b1;
        if (wrap_s) begin
            cnt_next_s = {DIV_W{1'b0}};
            if (pend_r) begin
                div_next_s = div_pend_r;
            end else begin
                div_next_s = div_cur_r;
            end
        end else begin
            cnt_next_s = cnt_r + DIV_W'(1);
            div_next_s = div_cur_r;
        end
    end

    // Divider registers; clkout follows the phase of the previous cycle so it never runts
    always_ff @(posedge sysclk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            cnt_r      <= {DIV_W{1'b0}};
            div_cur_r  <= DIV_W'(DIV_DEFAULT);
            div_pend_r <= DIV_W'(DIV_DEFAULT);
            pend_r     <= 1'b0;
            clk_en_r   <= 1'b0;
            clkout_r   <= 1'b0;
        end else begin
            cnt_r     <= cnt_next_s;
            div_cur_r <= div_next_s;
            clk_en_r  <= (cnt_next_s == (div_next_s - DIV_W'(1)));
            clkout_r  <= ({1'b0, cnt_r} < half_s);
            if (div_load) begin
                div_pend_r <= load_val_s;
                pend_r     <= 1'b1;
            end else if (wrap_s) begin
                pend_r <= 1'b0;
            end
        end
    end

    assign clkout  = clkout_r;
    assign clk_en  = clk_en_r;
    assign div_cur = div_cur_r;

    // ---------------- reset sequencer ----------------
    rst_state_e        state_r, state_next_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_next_s;
    logic [GAP_W-1:0]  gap_cnt_r, gap_next_s;
    logic [IDX_W-1:0]  idx_r, idx_next_s;
    logic [IDX_W:0]    idx_inc_s;
    logic [N_RST-1:0]  rst_n_r, rst_next_s;
    logic              busy_r, busy_next_s;

    // Sequencer state and its registered outputs
    always_ff @(posedge sysclk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r    <= HOLD;
            hold_cnt_r <= {HOLD_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            rst_n_r    <= {N_RST{1'b0}};
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            hold_cnt_r <= hold_next_s;
            gap_cnt_r  <= gap_next_s;
            idx_r      <= idx_next_s;
            rst_n_r    <= rst_next_s;
            busy_r     <= busy_next_s;
        end
    end

    // Sequencer next-state: ndmreset overrides everything, otherwise step on clk_en
    always_comb begin
        state_next_s = state_r;
        hold_next_s  = hold_cnt_r;
        gap_next_s   = gap_cnt_r;
        idx_next_s   = idx_r;
        rst_next_s   = rst_n_r;
        busy_next_s  = busy_r;
        idx_inc_s    = {1'b0, idx_r} + (IDX_W+1)'(1);
        if (ndm_s) begin
            state_next_s = HOLD;
            hold_next_s  = {HOLD_W{1'b0}};
            gap_next_s   = {GAP_W{1'b0}};
            idx_next_s   = {IDX_W{1'b0}};
            rst_next_s   = {N_RST{1'b0}};
            busy_next_s  = 1'b1;
        end else if (clk_en_r) begin
            case (state_r)
                HOLD: begin
                    if (hold_cnt_r == HOLD_W'(RST_HOLD - 1)) begin
                        hold_next_s  = {HOLD_W{1'b0}};
                        gap_next_s   = {GAP_W{1'b0}};
                        idx_next_s   = {IDX_W{1'b0}};
                        rst_next_s   = RST_ONE;
                        if (N_RST == 1) begin
                            state_next_s = RUN;
                            busy_next_s  = 1'b0;
                        end else begin
                            state_next_s = RELEASE;
                        end
                    end else begin
                        hold_next_s = hold_cnt_r + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt_r == GAP_W'(STEP_GAP - 1)) begin
                        gap_next_s = {GAP_W{1'b0}};
                        rst_next_s = rst_n_r | (RST_ONE << idx_inc_s);
                        idx_next_s = idx_inc_s[IDX_W-1:0];
                        if (idx_inc_s == (IDX_W+1)'(N_RST - 1)) begin
                            state_next_s = RUN;
                            busy_next_s  = 1'b0;
                        end else begin
                            state_next_s = RELEASE;
                        end
                    end else begin
                        gap_next_s = gap_cnt_r + GAP_W'(1);
                    end
                end
                RUN: begin
                    busy_next_s = 1'b0;
                end
                default: begin
                    state_next_s = HOLD;
                    hold_next_s  = {HOLD_W{1'b0}};
                    rst_next_s   = {N_RST{1'b0}};
                    busy_next_s  = 1'b1;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    assign rst_n_out = rst_n_r;
    assign busy      = busy_r;

`ifdef CLK_RST_CAUSE_EN
    logic       ndm_q_r;
    logic [1:0] cause_r, cause_next_s;

    // Sticky cause bits; a new ndmreset entry wins over a simultaneous clear
    always_comb begin
        if (cause_clr) begin
            cause_next_s = 2'b00;
        end else begin
            cause_next_s = cause_r;
        end
        if (ndm_s && !ndm_q_r) begin
            cause_next_s[CAUSE_NDM] = 1'b1;
        end else begin
            cause_next_s[CAUSE_NDM] = cause_next_s[CAUSE_NDM];
        end
    end

    // Cause register; power-on/system reset leaves the POR bit set
    always_ff @(posedge sysclk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            ndm_q_r <= 1'b0;
            cause_r <= 2'b01;
        end else begin
            ndm_q_r <= ndm_s;
            cause_r <= cause_next_s;
        end
    end

    assign rst_cause = cause_r;
`endif

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Self-checking bench for clk_rst_ctrl: per-cycle behavioural model plus directed checks.
module tb_clk_rst_ctrl;

    localparam int DIV_W       = 4;
    localparam int DIV_DEFAULT = 2;
    localparam int N_RST       = 2;
    localparam int SYNC_STAGES = 2;
    localparam int RST_HOLD    = 16;
    localparam int STEP_GAP    = 4;

    logic             sysclk   = 1'b0;
    logic             sysrst_n = 1'b0;
    logic             ndmreset = 1'b0;
    logic [DIV_W-1:0] div_set  = 4'd0;
    logic             div_load = 1'b0;
    logic             clkout, clk_en, busy;
    logic [N_RST-1:0] rst_n_out;
    logic [DIV_W-1:0] div_cur;
`ifdef CLK_RST_CAUSE_EN
    logic             cause_clr = 1'b0;
    logic [1:0]       rst_cause;
`endif

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    clk_rst_ctrl #(
        .DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT), .N_RST(N_RST),
        .SYNC_STAGES(SYNC_STAGES), .RST_HOLD(RST_HOLD), .STEP_GAP(STEP_GAP)
    ) dut (
        .sysclk    (sysclk),
        .sysrst_n  (sysrst_n),
        .ndmreset  (ndmreset),
        .div_set   (div_set),
        .div_load  (div_load),
`ifdef CLK_RST_CAUSE_EN
        .cause_clr (cause_clr),
        .rst_cause (rst_cause),
`endif
        .clkout    (clkout),
        .clk_en    (clk_en),
        .rst_n_out (rst_n_out),
        .busy      (busy),
        .div_cur   (div_cur)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time-based view: the divider is a phase counter, and each reset bit is
    // simply "enough divided periods have elapsed since the last reset source".
    int m_rsync   = 0;
    int m_ndm_hist[SYNC_STAGES];
    int m_phase   = 0;
    int m_div     = DIV_DEFAULT;
    int m_pend    = 0;
    int m_pval    = DIV_DEFAULT;
    int m_periods = 0;
    int m_clkout  = 0;

    task automatic model_reset();
        m_rsync = 0;
        for (int i = 0; i < SYNC_STAGES; i++) m_ndm_hist[i] = 0;
        m_phase = 0; m_div = DIV_DEFAULT; m_pend = 0; m_pval = DIV_DEFAULT;
        m_periods = 0; m_clkout = 0;
    endtask

    task automatic model_tick();
        int ndm_seen;
        int wrap;
        ndm_seen = m_ndm_hist[SYNC_STAGES-1];
        for (int i = SYNC_STAGES-1; i > 0; i--) m_ndm_hist[i] = m_ndm_hist[i-1];
        m_ndm_hist[0] = int'(ndmreset);
        if (m_rsync < SYNC_STAGES) begin
            m_rsync++;
        end else begin
            m_clkout = (m_phase < (m_div + 1) / 2) ? 1 : 0;
            wrap = (m_phase == m_div - 1) ? 1 : 0;
            if (ndm_seen != 0) m_periods = 0;
            else if (wrap != 0 && m_periods < 1000) m_periods++;
            if (wrap != 0) begin
                m_phase = 0;
                if (m_pend != 0) begin
                    m_div = m_pval;
                    m_pend = 0;
                end
            end else begin
                m_phase++;
            end
            if (div_load) begin
                m_pval = (int'(div_set) < 2) ? 2 : int'(div_set);
                m_pend = 1;
            end
        end
    endtask

    function automatic int exp_rst();
        int v;
        v = 0;
        for (int i = 0; i < N_RST; i++)
            if (m_periods >= RST_HOLD + i * STEP_GAP) v = v | (1 << i);
        return v;
    endfunction

    function automatic int exp_busy();
        return (m_periods < RST_HOLD + (N_RST - 1) * STEP_GAP) ? 1 : 0;
    endfunction

    // Model advance on every active edge
    always @(posedge sysclk) begin
        if (!sysrst_n) model_reset();
        else model_tick();
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge sysclk) begin
        check("clkout", int'(clkout), m_clkout);
        check("clk_en", int'(clk_en), (m_phase == m_div - 1) ? 1 : 0);
        check("rst_n_out", int'(rst_n_out), exp_rst());
        check("busy", int'(busy), exp_busy());
        check("div_cur", int'(div_cur), m_div);
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(negedge sysclk);
        #1;
    endtask

    task automatic load_div(input int v);
        div_set  = DIV_W'(v);
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
    endtask

    task automatic count_en_until(input int b, input string name, output int n);
        int ok;
        n = 0; ok = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (rst_n_out[b]) begin
                ok = 1;
                break;
            end
            if (clk_en) n++;
        end
        check({name, "_seen"}, ok, 1);
    endtask

    task automatic measure(output int hi, output int per);
        int ok;
        logic prev;
        hi = 0; per = 0; ok = 0;
        for (int c = 0; c < 100; c++) begin
            prev = clkout;
            tick();
            if (!prev && clkout) begin
                ok = 1;
                break;
            end
        end
        check("clkout_rise_seen", ok, 1);
        for (int c = 0; c < 100 && clkout; c++) begin hi++; tick(); end
        per = hi;
        for (int c = 0; c < 100 && !clkout; c++) begin per++; tick(); end
    endtask

    task automatic wait_en_level(input logic lvl);
        int ok;
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            if (clk_en == lvl) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("clk_en_level_seen", ok, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, hi, per, ndm_left;
        repeat (3) tick();
        check("por_clkout", int'(clkout), 0);
        check("por_clk_en", int'(clk_en), 0);
        check("por_rst", int'(rst_n_out), 0);
        check("por_busy", int'(busy), 1);
        check("por_div", int'(div_cur), 2);

        sysrst_n = 1'b1;
        count_en_until(0, "por_rst0", n);
        check("por_rst0_periods", n, 16);
        check("por_busy_mid", int'(busy), 1);
        count_en_until(1, "por_rst1", n);
        check("por_rst1_periods", n, 4);
        check("por_busy_done", int'(busy), 0);
`ifdef CLK_RST_CAUSE_EN
        check("cause_por", int'(rst_cause), 1);
`endif
        measure(hi, per);
        check("div2_period", per, 2);
        check("div2_high", hi, 1);

        wait_en_level(1'b0);
        load_div(5);
        check("div5_deferred_en", int'(clk_en), 1);
        check("div5_deferred", int'(div_cur), 2);
        tick();
        check("div5_applied", int'(div_cur), 5);
        measure(hi, per);
        check("div5_period", per, 5);
        check("div5_high", hi, 3);

        load_div(1);
        repeat (15) tick();
        check("clamp1", int'(div_cur), 2);
        load_div(6);
        repeat (20) tick();
        check("div6", int'(div_cur), 6);
        load_div(0);
        repeat (20) tick();
        check("clamp0", int'(div_cur), 2);

        load_div(15);
        repeat (35) tick();
        check("div15", int'(div_cur), 15);
        wait_en_level(1'b1);
        tick();
        load_div(7);
        load_div(3);
        repeat (40) tick();
        check("double_load", int'(div_cur), 3);
        measure(hi, per);
        check("div3_period", per, 3);
        check("div3_high", hi, 2);

        ndmreset = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n++;
            if (rst_n_out == 2'b00) break;
        end
        check("ndm_latency", (n <= SYNC_STAGES + 1 && rst_n_out == 2'b00) ? 1 : 0, 1);
        check("ndm_busy", int'(busy), 1);
        repeat (10 - n) tick();
        ndmreset = 1'b0;
        count_en_until(0, "ndm_rst0", n);
        check("ndm_rst0_periods", (n >= 16 && n <= 17) ? 1 : 0, 1);
        count_en_until(1, "ndm_rst1", n);
        check("ndm_rst1_periods", n, 4);
        check("ndm_busy_done", int'(busy), 0);
        check("ndm_div_kept", int'(div_cur), 3);
`ifdef CLK_RST_CAUSE_EN
        check("cause_ndm", int'(rst_cause), 3);
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        tick();
        check("cause_clr", int'(rst_cause), 0);
`endif

        ndmreset = 1'b1;
        repeat (4) tick();
        ndmreset = 1'b0;
        count_en_until(0, "rel_rst0", n);
        check("rel_busy", int'(busy), 1);
        sysrst_n = 1'b0;
        #1;
        check("async_clkout", int'(clkout), 0);
        check("async_clk_en", int'(clk_en), 0);
        check("async_rst", int'(rst_n_out), 0);
        check("async_busy", int'(busy), 1);
        check("async_div", int'(div_cur), DIV_DEFAULT);
        repeat (3) tick();
        sysrst_n = 1'b1;
        count_en_until(0, "rerun_rst0", n);
        check("rerun_rst0_periods", n, 16);
`ifdef CLK_RST_CAUSE_EN
        check("cause_after_rst", int'(rst_cause), 1);
`endif

        ndm_left = 0;
        for (int c = 0; c < 3000; c++) begin
            div_set  = DIV_W'($urandom_range(0, 15));
            div_load = ($urandom_range(0, 19) == 0);
            if (ndm_left > 0) begin
                ndm_left--;
                ndmreset = (ndm_left != 0);
            end else if ($urandom_range(0, 299) == 0) begin
                ndm_left = $urandom_range(1, 20);
                ndmreset = 1'b1;
            end
            if (!sysrst_n) sysrst_n = 1'b1;
            else if ($urandom_range(0, 1499) == 0) sysrst_n = 1'b0;
            tick();
        end
        div_load = 1'b0;
        ndmreset = 1'b0;
        sysrst_n = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
